// File: rtl/shadow_pkg.sv
// Shared shadow-chain definitions used by both the capture and receive sides.
// Holds the controller state encoding and default frame/buffer sizing.
package shadow_pkg;

  localparam int DEF_FRAME_BITS = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DUMP  = 2'd1,
    ST_DRAIN = 2'd2
  } sh_state_t;

  // Width of a bit-count field able to hold 0..frame_bits inclusive.
  function automatic int nbits_w(input int frame_bits);
    return $clog2(frame_bits + 1);
  endfunction

endpackage

// File: rtl/shadow_rx_fifo.sv
// Purpose: synchronous frame buffer between chain assembly and the consumer.
// Latency: push visible on pop side one cycle later (registered, no bypass).
// Backpressure: pop only when pop_rdy and not empty; push into full accepted only with a same-cycle pop.
module shadow_rx_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             sh_clk,
  input  logic             sh_rst_l,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic             pop_vld,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop_rdy && !empty;
  assign do_push = push_vld && (!full || do_pop);

  assign pop_vld = !empty;
  // Data is forced to zero when nothing is held so idle outputs are clean.
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge sh_clk or negedge sh_rst_l) begin
    if (!sh_rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sh_clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/shadow_chain_rx.sv
// Purpose: assemble a serial shadow-chain dump into MSB-first frames and buffer them.
// Latency: one cycle from frame completion to frame_vld.
// Backpressure: frame_vld/frame_rdy; a frame arriving at a full buffer is dropped and ovf latches.
module shadow_chain_rx
  import shadow_pkg::*;
#(
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                              sh_clk,
  input  logic                              sh_rst_l,
  input  logic                              dump_req,
  output logic                              dump_en,
  input  logic                              ch_in,
  input  logic                              ch_in_vld,
  input  logic                              ch_in_done,
  output logic [FRAME_BITS-1:0]             frame_data,
  output logic [$clog2(FRAME_BITS+1)-1:0]   frame_nbits,
  output logic                              frame_last,
  output logic                              frame_vld,
  input  logic                              frame_rdy,
  output logic                              busy,
  output logic                              ovf,
  input  logic                              clr_ovf
);

  localparam int NBW = nbits_w(FRAME_BITS);
  localparam int FW  = FRAME_BITS + NBW + 1;

  sh_state_t             state_q, state_nxt;
  logic [FRAME_BITS-1:0] asm_q, asm_nxt, bit_mask;
  logic [NBW-1:0]        cnt_q, cnt_nxt;
  logic                  bit_in, done_in, full_frame, push, drop, dump_start;
  logic                  fifo_full, fifo_empty;
  logic [FW-1:0]         push_dat, pop_dat;

  assign bit_in     = (state_q == ST_DUMP) && ch_in_vld;
  assign done_in    = (state_q == ST_DUMP) && ch_in_done;
  assign dump_start = (state_q == ST_IDLE) && dump_req;

  // A coincident bit is folded in before the done marker is acted on.
  assign bit_mask   = FRAME_BITS'(1) << (NBW'(FRAME_BITS - 1) - cnt_q);
  assign asm_nxt    = (bit_in && ch_in) ? (asm_q | bit_mask) : asm_q;
  assign cnt_nxt    = cnt_q + NBW'(bit_in);
  assign full_frame = bit_in && (cnt_nxt == NBW'(FRAME_BITS));
  assign push       = full_frame || done_in;
  assign push_dat   = {asm_nxt, cnt_nxt, done_in};
  assign drop       = push && fifo_full && !frame_rdy;

  always_ff @(posedge sh_clk or negedge sh_rst_l) begin
    if (!sh_rst_l) begin
      state_q <= ST_IDLE;
      asm_q   <= '0;
      cnt_q   <= '0;
      dump_en <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_nxt;
      dump_en <= dump_start;
      if (push) begin
        asm_q <= '0;
        cnt_q <= '0;
      end else begin
        asm_q <= asm_nxt;
        cnt_q <= cnt_nxt;
      end
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (dump_start) state_nxt = ST_DUMP;
      ST_DUMP:  if (done_in) state_nxt = ST_DRAIN;
      ST_DRAIN: if (fifo_empty && !push) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  shadow_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sh_clk   (sh_clk),
    .sh_rst_l (sh_rst_l),
    .push_vld (push),
    .push_dat (push_dat),
    .pop_rdy  (frame_rdy),
    .pop_vld  (frame_vld),
    .pop_dat  (pop_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign {frame_data, frame_nbits, frame_last} = pop_dat;

endmodule

// File: tb/tb_shadow_chain_rx.sv
// Directed bench for shadow_chain_rx: stimulus queues expected frames, a monitor pops and compares.
module tb_shadow_chain_rx;

  logic       sh_clk = 1'b0;
  logic       sh_rst_l = 1'b0;
  logic       dump_req = 1'b0;
  logic       dump_en;
  logic       ch_in = 1'b0;
  logic       ch_in_vld = 1'b0;
  logic       ch_in_done = 1'b0;
  logic [7:0] frame_data;
  logic [3:0] frame_nbits;
  logic       frame_last;
  logic       frame_vld;
  logic       frame_rdy = 1'b0;
  logic       busy;
  logic       ovf;
  logic       clr_ovf = 1'b0;

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] n;
    logic       l;
  } frm_t;

  frm_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  shadow_chain_rx #(.FRAME_BITS(8), .FIFO_DEPTH(4)) dut (
    .sh_clk      (sh_clk),
    .sh_rst_l    (sh_rst_l),
    .dump_req    (dump_req),
    .dump_en     (dump_en),
    .ch_in       (ch_in),
    .ch_in_vld   (ch_in_vld),
    .ch_in_done  (ch_in_done),
    .frame_data  (frame_data),
    .frame_nbits (frame_nbits),
    .frame_last  (frame_last),
    .frame_vld   (frame_vld),
    .frame_rdy   (frame_rdy),
    .busy        (busy),
    .ovf         (ovf),
    .clr_ovf     (clr_ovf)
  );

  always #5 sh_clk = ~sh_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: a frame is consumed at the next rising edge when vld and rdy are both high.
  always @(negedge sh_clk) begin : monitor
    frm_t e;
    if (sh_rst_l && frame_vld && frame_rdy) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_frame actual=%h/%0d/%0d required=none",
                 frame_data, frame_nbits, frame_last);
      end else begin
        e = exp_q.pop_front();
        if ({frame_data, frame_nbits, frame_last} !== e) begin
          failures++;
          $display("FAIL frame actual=%h/%0d/%0d required=%h/%0d/%0d",
                   frame_data, frame_nbits, frame_last, e.d, e.n, e.l);
        end
      end
    end
  end

  task automatic tick();
    @(posedge sh_clk);
    #1;
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic [3:0] n, input logic l);
    exp_q.push_back('{d: d, n: n, l: l});
  endtask

  task automatic send_bit(input logic b);
    ch_in = b;
    ch_in_vld = 1'b1;
    tick();
    ch_in_vld = 1'b0;
    ch_in = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic start_dump();
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
  endtask

  task automatic end_dump();
    ch_in_done = 1'b1;
    tick();
    ch_in_done = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    tick();
    check({name, "_busy"}, busy, 0);
    check({name, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_dump_en", dump_en, 0);
    check("rst_frame_vld", frame_vld, 0);
    check("rst_frame_data", frame_data, 0);
    check("rst_frame_nbits", frame_nbits, 0);
    check("rst_frame_last", frame_last, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    sh_rst_l = 1'b1;
    tick();
    frame_rdy = 1'b1;

    // Full frame then empty terminator
    expect_frame(8'hB2, 4'd8, 1'b0);
    expect_frame(8'h00, 4'd0, 1'b1);
    start_dump();
    check("t1_dump_en_first", dump_en, 1);
    check("t1_busy", busy, 1);
    send_bit(1'b1);
    check("t1_dump_en_second", dump_en, 0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    end_dump();
    wait_idle("t1");

    // 11 ones, done on following cycle
    expect_frame(8'hFF, 4'd8, 1'b0);
    expect_frame(8'hE0, 4'd3, 1'b1);
    start_dump();
    for (int i = 0; i < 11; i++) send_bit(1'b1);
    end_dump();
    wait_idle("t2");

    // Done coincident with 8th bit: single last frame
    expect_frame(8'h5D, 4'd8, 1'b1);
    start_dump();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    ch_in = 1'b1; ch_in_vld = 1'b1; ch_in_done = 1'b1;
    tick();
    ch_in = 1'b0; ch_in_vld = 1'b0; ch_in_done = 1'b0;
    wait_idle("t3");

    // Overflow: six frames and terminator into a depth-4 buffer with no consumer
    frame_rdy = 1'b0;
    start_dump();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
    end_dump();
    repeat (3) tick();
    check("t4_ovf_set", ovf, 1);
    check("t4_busy_held", busy, 1);
    check("t4_vld_held", frame_vld, 1);
    check("t4_head_data", frame_data, 8'h11);
    tick();
    check("t4_head_stable", {frame_data, frame_nbits, frame_last}, {8'h11, 4'd8, 1'b0});
    expect_frame(8'h11, 4'd8, 1'b0);
    expect_frame(8'h22, 4'd8, 1'b0);
    expect_frame(8'h33, 4'd8, 1'b0);
    expect_frame(8'h44, 4'd8, 1'b0);
    frame_rdy = 1'b1;
    wait_idle("t4");
    check("t4_ovf_sticky", ovf, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t4_ovf_cleared", ovf, 0);

    // Reset mid-dump with one buffered frame and five partial bits
    frame_rdy = 1'b0;
    start_dump();
    send_byte(8'hC3);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    sh_rst_l = 1'b0;
    #1;
    check("t5_rst_vld", frame_vld, 0);
    check("t5_rst_data", frame_data, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_dump_en", dump_en, 0);
    check("t5_rst_nbits_last", {frame_nbits, frame_last}, 0);
    tick();
    sh_rst_l = 1'b1;
    tick();
    check("t5_post_rst_vld", frame_vld, 0);
    frame_rdy = 1'b1;
    expect_frame(8'h0F, 4'd8, 1'b0);
    expect_frame(8'h00, 4'd0, 1'b1);
    start_dump();
    send_byte(8'h0F);
    end_dump();
    wait_idle("t5");

    // Chain inputs in IDLE and dump_req during DUMP are ignored
    ch_in = 1'b1; ch_in_vld = 1'b1; ch_in_done = 1'b1;
    repeat (3) tick();
    ch_in = 1'b0; ch_in_vld = 1'b0; ch_in_done = 1'b0;
    tick();
    check("t6_idle_busy", busy, 0);
    check("t6_idle_vld", frame_vld, 0);
    expect_frame(8'hAA, 4'd8, 1'b0);
    expect_frame(8'h00, 4'd0, 1'b1);
    start_dump();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    dump_req = 1'b1;
    send_bit(1'b0);
    dump_req = 1'b0;
    check("t6_redump_en", dump_en, 0);
    check("t6_redump_busy", busy, 1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    end_dump();
    wait_idle("t6");
    check("t6_ovf", ovf, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shadow_chain_rx.md
SHADOW_CHAIN_RX -- requirements
Module: shadow_chain_rx

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 8, meaning serial bits per received frame.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2), meaning number of frame buffer entries.
REQ-003 SHALL have port sh_clk, input, 1, the single shadow/data clock; all state is on its rising edge.
REQ-004 SHALL have port sh_rst_l, input, 1, reset, asynchronous assert, active-low.
REQ-005 SHALL have port dump_req, input, 1, single-cycle request to start one chain dump.
REQ-006 SHALL have port dump_en, output, 1, dump enable driven to the capture chain source.
REQ-007 SHALL have port ch_in, input, 1, serial chain data bit.
REQ-008 SHALL have port ch_in_vld, input, 1, ch_in holds a valid bit this cycle.
REQ-009 SHALL have port ch_in_done, input, 1, single-cycle end-of-chain marker.
REQ-010 SHALL have port frame_data, output, FRAME_BITS, assembled frame.
REQ-011 SHALL have port frame_nbits, output, clog2(FRAME_BITS+1), number of valid bits in frame_data.
REQ-012 SHALL have port frame_last, output, 1, frame is the final frame of the dump.
REQ-013 SHALL have port frame_vld, output, 1, frame outputs valid.
REQ-014 SHALL have port frame_rdy, input, 1, consumer accepts frame.
REQ-015 SHALL have port busy, output, 1, state is not IDLE.
REQ-016 SHALL have port ovf, output, 1, sticky frame-drop flag.
REQ-017 SHALL have port clr_ovf, input, 1, clears ovf.

Function
REQ-018 SHALL implement FSM states IDLE, DUMP, DRAIN.
REQ-019 SHALL move IDLE->DUMP on dump_req, asserting dump_en for exactly the first DUMP cycle; dump_req outside IDLE SHALL be ignored.
REQ-020 SHALL, in DUMP, write each ch_in_vld bit to frame position FRAME_BITS-1-cnt (MSB first), then increment cnt.
REQ-021 SHALL push {frame, nbits=FRAME_BITS, last=0} into the FIFO when cnt reaches FRAME_BITS, and clear the assembly register and cnt in the same cycle.
REQ-022 SHALL, on ch_in_done (DUMP only), push a terminator: partial frame left-justified, zero low bits, nbits=cnt, last=1; if cnt==0, all-zero data, nbits=0, last=1.
REQ-023 SHALL, when ch_in_done and ch_in_vld coincide, include that bit first; if it completes a frame, push that full frame with last=1 and no extra terminator.
REQ-024 SHALL move DUMP->DRAIN on ch_in_done, and DRAIN->IDLE once the FIFO is empty with no push pending.
REQ-025 SHALL ignore ch_in_vld and ch_in_done in IDLE and DRAIN.
REQ-026 SHALL accept a push into a full FIFO only when a pop occurs in the same cycle; otherwise drop the frame and set ovf.
REQ-027 SHALL, when the dropped frame is the terminator, still reach IDLE normally, with ovf set.
REQ-028 SHALL give ovf set priority over clr_ovf in the same cycle.
REQ-029 SHALL obey valid/ready: pop when frame_vld and frame_rdy; outputs stable while frame_vld and not frame_rdy.
REQ-030 SHALL have a push-to-frame_vld latency of one cycle (registered FIFO, no bypass).

Reset
REQ-031 SHALL, while sh_rst_l is low, hold state IDLE, FIFO empty, cnt 0, and outputs dump_en=0, frame_vld=0, frame_data=0, frame_nbits=0, frame_last=0, busy=0, ovf=0.
REQ-032 SHALL, on reset mid-dump, discard all partial and buffered frames; the first post-reset dump starts clean.

Structure
REQ-033 SHALL take the state encoding and default FRAME_BITS/FIFO_DEPTH constants from shared package shadow_pkg, which the shadow_capture side also uses.
REQ-034 SHALL use one sub-module, shadow_rx_fifo: a synchronous FIFO of width FRAME_BITS+clog2(FRAME_BITS+1)+1 with full/empty outputs.

Verification
REQ-035 SHALL cover: dump_req, then bits 1,0,1,1,0,0,1,0, then done -> frame 8'hB2 nbits=8 last=0, then terminator 8'h00 nbits=0 last=1; busy=0 after both pops.
REQ-036 SHALL cover: 11 bits all 1, done on cycle after the 11th bit -> 8'hFF nbits=8 last=0, then 8'hE0 nbits=3 last=1.
REQ-037 SHALL cover: done coincident with the 8th valid bit -> a single frame, nbits=8, last=1, and no terminator frame.
REQ-038 SHALL cover: frame_rdy=0 while 6 full frames arrive (depth 4) -> 4 frames retained in order, ovf=1, busy stays 1 until drained; clr_ovf then clears ovf.
REQ-039 SHALL cover: sh_rst_l low after 5 bits of a dump -> all outputs at reset values immediately; a new dump yields only fresh data.
REQ-040 SHALL cover: dump_req during DUMP, and ch_in_vld in IDLE -> no effect on state, cnt, or FIFO.
